fetch_queue: RTL and testbench

Instruction prefetch stage that sits between the instruction memory and the datapath's decode stage. It generates the fetch PC and issues requests over a request/grant memory handshake. Responses, tagged with their PC, are buffered in an in-order queue, and one instruction is presented to decode per cycle. It absorbs decode stalls (stall_D) and discards wrong-path fetches on a redirect from the jump/branch path (pc_SEL/flush_D).

---
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues word-aligned fetches under a credit limit,
// buffers in-order responses tagged with their PC and presents one per cycle to decode.
module fetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       stall_D,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr,
  output logic [XLEN-1:0]            instr_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Stale responses can pile up across repeated redirects against a slow memory.
  localparam int DW = CW + 4;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, outstanding;
  logic [DW-1:0]   drop, in_flight, drop_redirect;
  logic [CW:0]     used;
  logic            credit, issue, push, pop;

  always_comb begin
    used          = {1'b0, count} + {1'b0, outstanding};
    credit        = used < (CW+1)'(DEPTH);
    imem_req      = reset & credit & ~redirect_valid;
    imem_addr     = fetch_pc;
    issue         = imem_req & imem_gnt;
    push          = imem_rvalid & (drop == '0) & (outstanding != '0) & ~redirect_valid;
    pop           = (count != '0) & ~stall_D & ~redirect_valid;
    in_flight     = drop + DW'(outstanding);
    drop_redirect = (imem_rvalid && in_flight != '0) ? in_flight - DW'(1) : in_flight;
    instr_valid   = (count != '0);
    instr         = instr_valid ? q_data[head] : NOP;
    instr_pc      = instr_valid ? q_pc[head]   : '0;
    occupancy     = count;
  end

  // Control state: PCs, pointers and credit/drop bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= word_align(redirect_pc);
      resp_pc     <= word_align(redirect_pc);
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= drop_redirect;
    end else begin
      if (issue) fetch_pc <= next_pc(fetch_pc);
      if (push) begin
        resp_pc <= next_pc(resp_pc);
        tail    <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(push);
      if (imem_rvalid && drop != '0) drop <= drop - DW'(1);
    end
  end

  // Queue storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= resp_pc;
      q_data[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model drives the handshake and a
// queue-based reference model predicts every output each cycle.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_D;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_D        (stall_D),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  mreq_t       mem_q[$];
  bit          live_q[$];
  logic [31:0] mq_pc[$];
  logic [31:0] mq_data[$];
  logic [31:0] m_fetch, m_resp;
  int          p_gnt, p_rv, p_stall, p_redir, max_dly;
  bit          force_redir;
  logic [31:0] force_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    foreach (live_q[i]) if (live_q[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(7))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFC;
      2: return 32'hFFFF_FFF5;
      3: return 32'h0000_0100;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_outputs(input bit exp_req);
    chk("imem_req",    {31'b0, imem_req},    {31'b0, exp_req});
    chk("imem_addr",   imem_addr,            m_fetch);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq_pc.size() > 0});
    chk("instr",       instr,                (mq_pc.size() > 0) ? mq_data[0] : NOP);
    chk("instr_pc",    instr_pc,             (mq_pc.size() > 0) ? mq_pc[0] : 32'h0);
    chk("occupancy",   {29'b0, occupancy},   32'(mq_pc.size()));
  endtask

  task automatic step();
    bit   exp_req;
    bit   l;
    @(negedge clk);
    cyc++;
    imem_gnt       = ($urandom_range(99) < p_gnt);
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc    = force_redir ? force_pc : pick_pc();
    stall_D        = ($urandom_range(99) < p_stall);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req = ((mq_pc.size() + live_count()) < DEPTH) && !redirect_valid;
    check_outputs(exp_req);

    // memory environment reacts to the DUT handshake
    if (imem_rvalid) void'(mem_q.pop_front());
    if (imem_req && imem_gnt)
      mem_q.push_back('{addr: imem_addr, data: $urandom, due: cyc + 1 + $urandom_range(max_dly)});

    // reference model advances to the state after this clock edge
    if (redirect_valid) begin
      if (imem_rvalid && live_q.size() > 0) void'(live_q.pop_front());
      foreach (live_q[i]) live_q[i] = 1'b0;
      mq_pc.delete();
      mq_data.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_resp  = {redirect_pc[31:2], 2'b00};
    end else begin
      if (mq_pc.size() > 0 && !stall_D) begin
        void'(mq_pc.pop_front());
        void'(mq_data.pop_front());
      end
      if (imem_rvalid && live_q.size() > 0) begin
        l = live_q.pop_front();
        if (l) begin
          mq_pc.push_back(m_resp);
          mq_data.push_back(imem_rdata);
          m_resp = m_resp + 32'd4;
        end
      end
      if (exp_req && imem_gnt) begin
        live_q.push_back(1'b1);
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic set_mode(input int g, input int rv, input int st, input int rd, input int dly);
    p_gnt = g; p_rv = rv; p_stall = st; p_redir = rd; max_dly = dly;
  endtask

  task automatic model_reset();
    mem_q.delete();
    live_q.delete();
    mq_pc.delete();
    mq_data.delete();
    m_fetch = RESET_PC;
    m_resp  = RESET_PC;
  endtask

  task automatic idle_inputs();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_D        = 1'b0;
  endtask

  initial begin
    int budget;
    force_redir = 1'b0;
    force_pc    = '0;
    reset       = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b1;

    // streaming with single-cycle memory
    set_mode(100, 100, 0, 0, 0);
    repeat (20) step();

    // long stall fills the queue, then drains
    set_mode(100, 100, 100, 0, 0);
    repeat (8) step();
    chk("full_occupancy", {29'b0, occupancy}, 32'(DEPTH));
    chk("full_req", {31'b0, imem_req}, 32'd0);
    set_mode(100, 100, 0, 0, 0);
    repeat (8) step();

    // delayed responses, then redirects with misaligned and wrapping targets
    set_mode(100, 0, 0, 0, 0);
    repeat (2) step();
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    set_mode(100, 100, 0, 0, 2);
    repeat (10) step();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    set_mode(100, 100, 100, 0, 0);
    step();
    force_redir = 1'b0;
    set_mode(100, 100, 0, 0, 0);
    repeat (8) step();

    // broad random traffic
    set_mode(70, 70, 30, 10, 3);
    repeat (1500) step();

    // asynchronous reset with requests in flight and entries buffered
    set_mode(100, 60, 100, 0, 4);
    budget = 0;
    while (!(mem_q.size() >= 2 && mq_pc.size() >= 1) && budget < 500) begin
      step();
      budget++;
    end
    chk("reset_setup_reached", {31'b0, budget < 500}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    reset = 1'b1;
    set_mode(100, 100, 0, 0, 0);
    repeat (10) step();

    // redirect-heavy random traffic
    set_mode(80, 60, 40, 25, 3);
    repeat (1000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
